// File: rtl/a_rx_word_assembler.sv
// Assembles three UART bytes into an 18-bit word for the compare stage.
// Optional gap timeout on partial words is built when RX_TIMEOUT_EN is defined.
module a_rx_word_assembler #(
    parameter logic [5:0]  SYNC_TAG       = 6'b000000,
    parameter logic [19:0] TIMEOUT_CYCLES = 20'd50000
) (
    input  logic        clk_ref,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [17:0] data,
    output logic        data_valid,
    output logic        fmt_err,
    output logic        timeout_err,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, GOT1, GOT2} state_e;

    state_e      state_q, state_d;
    logic [1:0]  hi_q, hi_d;
    logic [7:0]  mid_q, mid_d;
    logic [17:0] data_q, data_d;
    logic        dv_q, dv_d;
    logic        fe_q, fe_d;
    logic        to_q, to_d;
    logic        acc;

    assign acc = rx_valid & enable;

`ifdef RX_TIMEOUT_EN
    logic [19:0] cnt_q, cnt_d;
`else
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        mid_d   = mid_q;
        data_d  = data_q;
        dv_d    = 1'b0;
        fe_d    = 1'b0;
        to_d    = 1'b0;
`ifdef RX_TIMEOUT_EN
        cnt_d   = 20'd0;
`endif
        unique case (state_q)
            IDLE: begin
                if (acc) begin
                    if (rx_data[7:2] == SYNC_TAG) begin
                        hi_d    = rx_data[1:0];
                        state_d = GOT1;
                    end else begin
                        fe_d = 1'b1;
                    end
                end
            end
            GOT1: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (acc) begin
                    mid_d   = rx_data;
                    state_d = GOT2;
                end
            end
            GOT2: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (acc) begin
                    data_d  = {hi_q, mid_q, rx_data};
                    dv_d    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef RX_TIMEOUT_EN
        // Idle cycle inside a partial word: count it or give up.
        if (state_q != IDLE && enable && !rx_valid) begin
            if (cnt_q == TIMEOUT_CYCLES - 20'd1) begin
                state_d = IDLE;
                to_d    = 1'b1;
            end else begin
                cnt_d = cnt_q + 20'd1;
            end
        end
`endif
    end

    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hi_q    <= 2'd0;
            mid_q   <= 8'd0;
            data_q  <= 18'd0;
            dv_q    <= 1'b0;
            fe_q    <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            mid_q   <= mid_d;
            data_q  <= data_d;
            dv_q    <= dv_d;
            fe_q    <= fe_d;
            to_q    <= to_d;
        end
    end

`ifdef RX_TIMEOUT_EN
    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 20'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign data        = data_q;
    assign data_valid  = dv_q;
    assign fmt_err     = fe_q;
    assign timeout_err = to_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_a_rx_word_assembler.sv
// Random and directed stimulus for the word assembler against a byte-list model.
// Define RX_TIMEOUT_EN to also exercise the gap timeout with an 8-cycle limit.
module tb_a_rx_word_assembler;

`ifdef RX_TIMEOUT_EN
    localparam logic [19:0] TMO = 20'd8;
    localparam bit          TMO_ON = 1'b1;
`else
    localparam logic [19:0] TMO = 20'd50000;
    localparam bit          TMO_ON = 1'b0;
`endif

    logic        clk_ref = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [17:0] data;
    logic        data_valid;
    logic        fmt_err;
    logic        timeout_err;
    logic        busy;

    int n_chk = 0;
    int n_err = 0;

    // Model: bytes of the word in progress, idle-cycle gap, last word.
    logic [7:0]  part[$];
    int          gap;
    logic [17:0] m_data;
    logic        m_dv, m_fe, m_to;

    always #5 clk_ref = ~clk_ref;

    a_rx_word_assembler #(
        .SYNC_TAG(6'b000000),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_ref(clk_ref),
        .rst_n(rst_n),
        .enable(enable),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .data(data),
        .data_valid(data_valid),
        .fmt_err(fmt_err),
        .timeout_err(timeout_err),
        .busy(busy)
    );

    task automatic chk(input string tag, input logic [17:0] obs,
                       input logic [17:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        part.delete();
        gap    = 0;
        m_data = 18'h0;
        m_dv   = 1'b0;
        m_fe   = 1'b0;
        m_to   = 1'b0;
    endtask

    task automatic model_step(input logic v, input logic en, input logic [7:0] d);
        m_dv = 1'b0;
        m_fe = 1'b0;
        m_to = 1'b0;
        if (part.size() > 0 && !en) begin
            part.delete();
            gap = 0;
        end else if (v && en) begin
            gap = 0;
            if (part.size() == 0) begin
                if (d[7:2] == 6'b000000) part.push_back(d);
                else m_fe = 1'b1;
            end else begin
                part.push_back(d);
                if (part.size() == 3) begin
                    m_data = {part[0][1:0], part[1], part[2]};
                    m_dv   = 1'b1;
                    part.delete();
                end
            end
        end else if (part.size() > 0) begin
            gap++;
            if (TMO_ON && gap == int'(TMO)) begin
                m_to = 1'b1;
                part.delete();
                gap = 0;
            end
        end
    endtask

    task automatic check_all();
        chk("data", data, m_data);
        chk("data_valid", 18'(data_valid), 18'(m_dv));
        chk("fmt_err", 18'(fmt_err), 18'(m_fe));
        chk("timeout_err", 18'(timeout_err), 18'(m_to));
        chk("busy", 18'(busy), 18'(part.size() > 0));
    endtask

    task automatic cyc(input logic v, input logic en, input logic [7:0] d);
        rx_valid = v;
        enable   = en;
        rx_data  = d;
        @(posedge clk_ref);
        model_step(v, en, d);
        #1;
        check_all();
    endtask

    initial begin
        rst_n    = 1'b0;
        enable   = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        model_reset();
        repeat (2) @(posedge clk_ref);
        #1;
        check_all();
        rst_n = 1'b1;

        // Back-to-back word
        cyc(1, 1, 8'h02);
        cyc(1, 1, 8'hAB);
        cyc(1, 1, 8'hCD);
        chk("b2b_word", data, 18'h2ABCD);
        chk("b2b_dv", 18'(data_valid), 18'h1);
        cyc(0, 1, 8'h00);
        chk("b2b_dv_once", 18'(data_valid), 18'h0);

        // Bad sync then a good word
        cyc(1, 1, 8'h43);
        chk("badsync_fe", 18'(fmt_err), 18'h1);
        cyc(1, 1, 8'h01);
        chk("badsync_fe_once", 18'(fmt_err), 18'h0);
        cyc(1, 1, 8'h00);
        cyc(1, 1, 8'h05);
        chk("badsync_word", data, 18'h10005);

        // Enable drop mid-word
        cyc(1, 1, 8'h03);
        cyc(1, 1, 8'hFF);
        cyc(1, 0, 8'h55);
        chk("endrop_busy", 18'(busy), 18'h0);
        cyc(1, 1, 8'h00);
        cyc(1, 1, 8'h12);
        cyc(1, 1, 8'h34);
        chk("endrop_word", data, 18'h01234);

        // Reset mid-word
        cyc(1, 1, 8'h02);
        cyc(1, 1, 8'h11);
        rx_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("rst_data", data, 18'h0);
        @(posedge clk_ref);
        #3;
        rst_n = 1'b1;
        cyc(1, 1, 8'h00);
        cyc(1, 1, 8'h00);
        cyc(1, 1, 8'h07);
        chk("rst_word", data, 18'h00007);

`ifdef RX_TIMEOUT_EN
        // Full gap expires
        cyc(1, 1, 8'h01);
        repeat (7) cyc(0, 1, 8'h00);
        chk("tmo_busy_hold", 18'(busy), 18'h1);
        cyc(0, 1, 8'h00);
        chk("tmo_pulse", 18'(timeout_err), 18'h1);
        chk("tmo_data", data, 18'h00007);
        // Byte on the last allowed gap cycle wins
        cyc(1, 1, 8'h01);
        repeat (7) cyc(0, 1, 8'h00);
        cyc(1, 1, 8'h9A);
        chk("tmo_edge_no_to", 18'(timeout_err), 18'h0);
        cyc(1, 1, 8'hBC);
        chk("tmo_edge_word", data, 18'h19ABC);
`endif

        // Randomised traffic with varied gaps and occasional enable drops
        for (int i = 0; i < 3000; i++) begin
            logic v, en;
            logic [7:0] d;
            v  = ($urandom_range(0, 99) < ((i / 300) % 2 == 0 ? 70 : 15));
            en = ($urandom_range(0, 99) < 95);
            d  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 3))
                                             : 8'($urandom);
            cyc(v, en, d);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
